inv_subbytes_iter: RTL
======================

Name: inv_subbytes_iter

Overview:
- Iterative inverse SubBytes engine for the AES decryption datapath. It replaces each byte of a 128-bit state with its FIPS-197 inverse S-box value.
- Processes LANES bytes per clock to trade area for latency, rather than instantiating 16 lookups.
- Sits between inverse ShiftRows and AddRoundKey in the decrypt round, using a valid/ready handshake on both sides.

Parameters:
- LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value is a build-time error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  state_in is valid
- in_ready  output  1  block can accept a state
- state_in  input  128  ciphertext-side state; byte i = state_in[8*i +: 8]
- out_valid  output  1  state_out holds a completed result
- out_ready  input  1  downstream accepts the result
- state_out  output  128  result; byte i = InvSbox(state_in byte i), same bit position

Behaviour:
- Reset (rst_n low, asynchronous): FSM to IDLE, byte counter = 0, internal state register = 0, state_out = 0, out_valid = 0, in_ready = 1 after release. Reset mid-RUN or mid-DONE aborts the operation; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready at an edge: capture state_in into the working register, clear the counter, go to RUN.
- RUN:
  - in_ready = 0, out_valid = 0. Each edge, bytes [cnt*LANES .. cnt*LANES+LANES-1] of the working register are replaced by their inverse S-box values, then cnt increments.
  - Bytes are processed in ascending index order. Unprocessed bytes keep their captured value.
  - After chunk 16/LANES-1 is written, go to DONE. Counter width is clog2(16/LANES), minimum 1 bit; the counter wraps to 0 on entering DONE.
- DONE:
  - out_valid = 1, state_out = working register, stable until handshake. in_ready = 0.
  - On out_ready & out_valid: go to IDLE and drop out_valid on the next cycle.
  - No new input is accepted in the same cycle as output handshake; throughput is one state per 16/LANES + 2 cycles.
- Latency: if acceptance is at edge T, out_valid rises after edge T + 16/LANES. LANES=4 gives 4 cycles; LANES=16 gives 1 cycle.
- state_out is a register output; it holds its last value in IDLE/RUN (0 after reset) and is updated only on entering DONE.
- in_valid while not in IDLE is ignored; the upstream must hold the state until in_ready.
- out_ready while not in DONE has no effect. out_ready held high gives DONE a dwell of exactly one cycle.
- Inverse S-box implementation: either a 256-entry case table or the inverse affine transform followed by GF(2^8) inversion modulo x^8+x^4+x^3+x+1, with InvSbox(0x00)=0x52. The implementation must be purely combinational per lane, with no extra pipeline stage.
- Inputs are not checked; every 8-bit value maps per FIPS-197.

Test Plan:
- Reset behaviour: assert rst_n=0 mid-RUN with LANES=4 -> out_valid=0, state_out=0 immediately; after release in_ready=1 and the next accepted state completes normally.
- Identity-inverse vector: state_in = 0x636363...63 (all bytes 0x63), out_ready=1 -> all output bytes 0x00; out_valid rises exactly 4 cycles after acceptance for LANES=4.
- Ascending bytes: byte i = i (state_in = 0x0f0e...0100) -> output bytes 0..15 = 52 09 6a d5 30 36 a5 38 bf 40 a3 9e 81 f3 d7 fb, checked for every legal LANES, with latency 16/LANES.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid stays 1, state_out is stable, in_ready=0 and a pulsed in_valid is ignored; raise out_ready -> one handshake, then IDLE.
- Round trip: 1000 random states passed through subbytes and then this block, with random in_valid/out_ready stalls -> output equals the original state and no result is dropped or duplicated.
- Edge values: byte values 0x00, 0xff, 0x52, 0xed -> 0x52, 0x7d, 0x48, 0x53.

Source files
------------

// File: rtl/inv_subbytes_iter.sv
// Iterative AES inverse SubBytes: substitutes LANES bytes of a 128-bit state per clock
// behind valid/ready handshakes on both the input and the output side.
module inv_subbytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  localparam int NCHUNK = 16 / LANES;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("inv_subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          fsm_r;
  logic [CW-1:0]   cnt_r;
  logic [127:0]    work_r;
  logic [127:0]    work_next_s;

  // Working state with the chunk selected by cnt_r substituted; other bytes pass through.
  always_comb begin
    work_next_s = work_r;
    for (int l = 0; l < LANES; l++) begin
      work_next_s[8*(int'(cnt_r)*LANES + l) +: 8] = inv_sbox(work_r[8*(int'(cnt_r)*LANES + l) +: 8]);
    end
  end

  // Control FSM with registered handshake outputs and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r     <= IDLE;
      cnt_r     <= {CW{1'b0}};
      work_r    <= 128'h0;
      state_out <= 128'h0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (in_valid) begin
            work_r   <= state_in;
            cnt_r    <= {CW{1'b0}};
            in_ready <= 1'b0;
            fsm_r    <= RUN;
          end
        end
        RUN: begin
          work_r <= work_next_s;
          if (cnt_r == LAST_CNT) begin
            cnt_r     <= {CW{1'b0}};
            state_out <= work_next_s;
            out_valid <= 1'b1;
            fsm_r     <= DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        DONE: begin
          // New input is only taken from IDLE, so a handshake here costs one idle cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            fsm_r     <= IDLE;
          end
        end
        default: begin
          cnt_r     <= {CW{1'b0}};
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          fsm_r     <= IDLE;
        end
      endcase
    end
  end

endmodule
